// File: rtl/hiz_tile_scheduler.sv
// Hi-Z tile max-depth store shared between the early-Z query port and the
// depth-commit update port, plus a clear engine that sweeps every tile.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | serve query/update requests, one grant per cycle
// ST_CLEAR | write clr_val into one tile per cycle, requests stalled
module hiz_tile_scheduler #(
  parameter int DEPTH_BITS = 24,
  parameter int TILE_BITS  = 6,
  parameter int CNT_BITS   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_req,
  input  logic [DEPTH_BITS-1:0] clear_z,
  output logic                  clear_busy,
  input  logic                  q_valid,
  output logic                  q_ready,
  input  logic [TILE_BITS-1:0]  q_tile,
  input  logic [DEPTH_BITS-1:0] q_z,
  output logic                  r_valid,
  output logic                  r_reject,
  input  logic                  u_valid,
  output logic                  u_ready,
  input  logic [TILE_BITS-1:0]  u_tile,
  input  logic [DEPTH_BITS-1:0] u_z,
  output logic [CNT_BITS-1:0]   reject_cnt
);

  localparam int NUM_TILES = 1 << TILE_BITS;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t                state_q, state_d;
  logic [DEPTH_BITS-1:0] tile_max_q [NUM_TILES];
  logic [DEPTH_BITS-1:0] tile_max_d [NUM_TILES];
  logic [DEPTH_BITS-1:0] clr_val_q, clr_val_d;
  logic [TILE_BITS-1:0]  clr_idx_q, clr_idx_d;
  logic                  rr_pri_q, rr_pri_d;
  logic                  clear_busy_q, clear_busy_d;
  logic                  r_valid_q, r_valid_d;
  logic                  r_reject_q, r_reject_d;
  logic [CNT_BITS-1:0]   reject_cnt_q, reject_cnt_d;
  logic                  q_grant, u_grant;

  // Arbitration: clear beats requests; round-robin only when both are valid.
  always_comb begin
    q_grant = 1'b0;
    u_grant = 1'b0;
    if (state_q == ST_IDLE && !clear_req) begin
      if (q_valid && u_valid) begin
        q_grant = !rr_pri_q;
        u_grant = rr_pri_q;
      end else begin
        q_grant = q_valid;
        u_grant = u_valid;
      end
    end
  end

  assign q_ready    = q_grant;
  assign u_ready    = u_grant;
  assign clear_busy = clear_busy_q;
  assign r_valid    = r_valid_q;
  assign r_reject   = r_reject_q;
  assign reject_cnt = reject_cnt_q;

  // Next-state computation for the FSM, tile store and result registers.
  always_comb begin
    state_d      = state_q;
    tile_max_d   = tile_max_q;
    clr_val_d    = clr_val_q;
    clr_idx_d    = clr_idx_q;
    rr_pri_d     = rr_pri_q;
    clear_busy_d = clear_busy_q;
    r_valid_d    = q_grant;
    r_reject_d   = r_reject_q;
    reject_cnt_d = reject_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          clr_val_d    = clear_z;
          clr_idx_d    = '0;
          clear_busy_d = 1'b1;
          state_d      = ST_CLEAR;
        end else begin
          if (q_valid && u_valid) rr_pri_d = !rr_pri_q;
          if (q_grant) begin
            r_reject_d = (q_z >= tile_max_q[q_tile]);
            if (r_reject_d && reject_cnt_q != '1)
              reject_cnt_d = reject_cnt_q + 1'b1;
          end
          // Monotonic max: only raises the entry, lowering needs a clear.
          if (u_grant && u_z > tile_max_q[u_tile])
            tile_max_d[u_tile] = u_z;
        end
      end
      ST_CLEAR: begin
        tile_max_d[clr_idx_q] = clr_val_q;
        clr_idx_d             = clr_idx_q + 1'b1;
        if (clr_idx_q == '1) begin
          clear_busy_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; async reset also aborts a running sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tile_max_q   <= '{default: '0};
      clr_val_q    <= '0;
      clr_idx_q    <= '0;
      rr_pri_q     <= 1'b0;
      clear_busy_q <= 1'b0;
      r_valid_q    <= 1'b0;
      r_reject_q   <= 1'b0;
      reject_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      tile_max_q   <= tile_max_d;
      clr_val_q    <= clr_val_d;
      clr_idx_q    <= clr_idx_d;
      rr_pri_q     <= rr_pri_d;
      clear_busy_q <= clear_busy_d;
      r_valid_q    <= r_valid_d;
      r_reject_q   <= r_reject_d;
      reject_cnt_q <= reject_cnt_d;
    end
  end

endmodule

// File: tb/tb_hiz_tile_scheduler.sv
// Directed bench for hiz_tile_scheduler: vector table plus hand sequences
// for arbitration, clear sweep and reset mid-sweep.
module tb_hiz_tile_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_req;
  logic [23:0] clear_z;
  logic        clear_busy;
  logic        q_valid, q_ready;
  logic [5:0]  q_tile;
  logic [23:0] q_z;
  logic        r_valid, r_reject;
  logic        u_valid, u_ready;
  logic [5:0]  u_tile;
  logic [23:0] u_z;
  logic [15:0] reject_cnt;

  typedef struct {
    bit          is_q;
    logic [5:0]  tile;
    logic [23:0] z;
    bit          exp_rej;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   exp_cnt = 0;
  int   busy_cnt;
  int   grant_seen;

  hiz_tile_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .clear_req  (clear_req),
    .clear_z    (clear_z),
    .clear_busy (clear_busy),
    .q_valid    (q_valid),
    .q_ready    (q_ready),
    .q_tile     (q_tile),
    .q_z        (q_z),
    .r_valid    (r_valid),
    .r_reject   (r_reject),
    .u_valid    (u_valid),
    .u_ready    (u_ready),
    .u_tile     (u_tile),
    .u_z        (u_z),
    .reject_cnt (reject_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(bit is_q, int tile, int z, bit rej);
    vec_t v;
    v.is_q    = is_q;
    v.tile    = tile[5:0];
    v.z       = z[23:0];
    v.exp_rej = rej;
    return v;
  endfunction

  // One isolated request: check its grant, then the registered result.
  task automatic apply(input vec_t v);
    @(negedge clk);
    if (v.is_q) begin
      q_valid = 1'b1; q_tile = v.tile; q_z = v.z;
    end else begin
      u_valid = 1'b1; u_tile = v.tile; u_z = v.z;
    end
    #1;
    check(v.is_q ? "q_ready" : "u_ready", {62'd0, q_ready, u_ready}, v.is_q ? 64'd2 : 64'd1);
    @(posedge clk);
    #1;
    q_valid = 1'b0;
    u_valid = 1'b0;
    check("r_valid", {63'd0, r_valid}, {63'd0, v.is_q});
    if (v.is_q) begin
      check($sformatf("r_reject t%0d z%0h", v.tile, v.z), {63'd0, r_reject}, {63'd0, v.exp_rej});
      if (v.exp_rej) exp_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; clear_req = 1'b0; clear_z = '0;
    q_valid = 1'b0; q_tile = '0; q_z = '0;
    u_valid = 1'b0; u_tile = '0; u_z = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst clear_busy", {63'd0, clear_busy}, 64'd0);
    check("rst r_valid", {63'd0, r_valid}, 64'd0);
    check("rst r_reject", {63'd0, r_reject}, 64'd0);
    check("rst reject_cnt", {48'd0, reject_cnt}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back(mk(1, 5,  'h0,      1));
    vecs.push_back(mk(0, 5,  'h100,    0));
    vecs.push_back(mk(1, 5,  'h0FF,    0));
    vecs.push_back(mk(1, 5,  'h100,    1));
    vecs.push_back(mk(0, 5,  'h080,    0));
    vecs.push_back(mk(1, 5,  'h0FF,    0));
    vecs.push_back(mk(1, 6,  'h0,      1));
    vecs.push_back(mk(0, 63, 'hFFFFFF, 0));
    vecs.push_back(mk(1, 63, 'hFFFFFE, 0));
    vecs.push_back(mk(1, 63, 'hFFFFFF, 1));
    vecs.push_back(mk(0, 0,  'h10,     0));
    vecs.push_back(mk(1, 0,  'h0F,     0));
    vecs.push_back(mk(1, 0,  'h10,     1));
    foreach (vecs[i]) apply(vecs[i]);
    check("reject_cnt table", {48'd0, reject_cnt}, 64'(exp_cnt));

    // Both valid for four cycles: Q,U,Q,U.
    @(negedge clk);
    q_valid = 1'b1; q_tile = 6'd1; q_z = '0;
    u_valid = 1'b1; u_tile = 6'd2; u_z = 24'h20;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      check($sformatf("rr grants c%0d", i), {62'd0, q_ready, u_ready},
            (i % 2 == 0) ? 64'd2 : 64'd1);
      @(posedge clk);
      #1;
      check($sformatf("rr r_valid c%0d", i), {63'd0, r_valid}, (i % 2 == 0) ? 64'd1 : 64'd0);
    end
    q_valid = 1'b0;
    u_valid = 1'b0;
    exp_cnt += 2;
    check("reject_cnt rr", {48'd0, reject_cnt}, 64'(exp_cnt));

    // Clear sweep with both requesters waiting; a clear_req mid-sweep is ignored.
    @(negedge clk);
    q_valid = 1'b1; q_tile = 6'd3; q_z = '0;
    u_valid = 1'b1; u_tile = 6'd4; u_z = 24'h5;
    clear_req = 1'b1; clear_z = 24'hFFFFFF;
    #1;
    check("clear beats grants", {62'd0, q_ready, u_ready}, 64'd0);
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    busy_cnt = 0;
    grant_seen = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i == 30) begin clear_req = 1'b1; clear_z = '0; end
      #1;
      if (clear_busy) busy_cnt++;
      if (q_ready || u_ready) grant_seen++;
      @(posedge clk);
      #1;
      clear_req = 1'b0;
    end
    @(negedge clk);
    #1;
    check("clear_busy after sweep", {63'd0, clear_busy}, 64'd0);
    check("clear busy cycles", 64'(busy_cnt), 64'd64);
    check("grants during clear", 64'(grant_seen), 64'd0);
    q_valid = 1'b0;
    u_valid = 1'b0;
    apply(mk(1, 0,  'hFFFFFE, 0));
    apply(mk(1, 31, 'hFFFFFE, 0));
    apply(mk(1, 63, 'hFFFFFE, 0));
    apply(mk(1, 5,  'hFFFFFE, 0));
    apply(mk(1, 7,  'hFFFFFF, 1));
    check("reject_cnt clear", {48'd0, reject_cnt}, 64'(exp_cnt));

    // Reset at sweep cycle 10 aborts the sweep and zeroes the store.
    @(negedge clk);
    clear_req = 1'b1; clear_z = 24'h123456;
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("busy before rst", {63'd0, clear_busy}, 64'd1);
    rst = 1'b1;
    #1;
    check("rst mid clear_busy", {63'd0, clear_busy}, 64'd0);
    check("rst mid reject_cnt", {48'd0, reject_cnt}, 64'd0);
    check("rst mid r_valid", {63'd0, r_valid}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    apply(mk(1, 0,  'h0, 1));
    apply(mk(1, 5,  'h0, 1));
    apply(mk(1, 9,  'h0, 1));
    apply(mk(1, 40, 'h0, 1));
    check("reject_cnt after rst", {48'd0, reject_cnt}, 64'(exp_cnt));

    // Idle cycle: r_valid drops, r_reject keeps its last value.
    @(posedge clk);
    #1;
    check("idle r_valid", {63'd0, r_valid}, 64'd0);
    check("idle r_reject hold", {63'd0, r_reject}, 64'd1);
    check("idle clear_busy", {63'd0, clear_busy}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
